// File: rtl/missile_scheduler_pkg.sv
// Shared constants, state encoding and LFSR step function for the invader missile scheduler.
package missile_scheduler_pkg;

  localparam int unsigned COL_PITCH_DEF   = 24;
  localparam int unsigned ROW_PITCH_DEF   = 24;
  localparam int unsigned HALF_SPRITE_DEF = 12;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Taps 16,14,13,11 of x^16 + x^14 + x^13 + x^11 + 1, left-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StScan   = 2'd1,
    StLaunch = 2'd2
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/missile_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock. Seed must be nonzero.
module missile_lfsr
  import missile_scheduler_pkg::*;
#(
  parameter logic [15:0] Seed = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = state_q;

endmodule

// File: rtl/missile_scheduler.sv
// Invader missile scheduler: per-frame cooldown, random live-column pick, launch coordinates,
// and a valid/ready hand-off to the missile datapath.
module missile_scheduler
  import missile_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 3,
  parameter int unsigned NUM_COLS        = 11,
  parameter int unsigned NUM_ROWS        = 5,
  parameter int unsigned COL_PITCH       = COL_PITCH_DEF,
  parameter int unsigned ROW_PITCH       = ROW_PITCH_DEF,
  parameter int unsigned HALF_SPRITE     = HALF_SPRITE_DEF,
  parameter int unsigned COOLDOWN_FRAMES = 32,
  parameter int unsigned MIN_COOLDOWN    = 8,
  parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame,
  input  logic [1:0]            speed,
  input  logic [9:0]            invaders_x,
  input  logic [9:0]            invaders_y,
  input  logic [NUM_COLS-1:0]   col_alive,
  input  logic [NUM_COLS*3-1:0] col_bottom,
  input  logic [NUM_SLOTS-1:0]  slot_busy,
  input  logic                  launch_ready,
  output logic                  launch_valid,
  output logic [1:0]            launch_slot,
  output logic [9:0]            launch_x,
  output logic [9:0]            launch_y
);

  localparam int unsigned ColW = $clog2(NUM_COLS);
  localparam int unsigned CdW  = $clog2(COOLDOWN_FRAMES + 1);

  // NUM_ROWS only bounds the legal range of col_bottom; the row field stays 3 bits wide.
  logic unused_rows;
  assign unused_rows = (NUM_ROWS > 8);

  state_e          state_q, state_d;
  logic [CdW-1:0]  cooldown_q, cooldown_d;
  logic [1:0]      slot_q, slot_d;
  logic [ColW-1:0] col_q, col_d;
  logic [ColW-1:0] scan_cnt_q, scan_cnt_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;

  logic [15:0]     lfsr_val;
  logic [ColW-1:0] start_col;
  logic [1:0]      free_slot;
  logic            any_free;
  logic [2:0]      bottom;
  logic [CdW-1:0]  reload_val;

  missile_lfsr #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .value_o(lfsr_val)
  );

  assign start_col = ColW'(lfsr_val % 16'(NUM_COLS));
  assign any_free  = ~&slot_busy;

  // Lowest-index free slot wins.
  always_comb begin
    free_slot = '0;
    for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        free_slot = 2'(s);
      end
    end
  end

  always_comb begin
    bottom = '0;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (col_q == ColW'(c)) begin
        bottom = col_bottom[3*c +: 3];
      end
    end
  end

  always_comb begin
    if ((COOLDOWN_FRAMES >> speed) > MIN_COOLDOWN) begin
      reload_val = CdW'(COOLDOWN_FRAMES >> speed);
    end else begin
      reload_val = CdW'(MIN_COOLDOWN);
    end
  end

  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    slot_d     = slot_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    x_d        = x_q;
    y_d        = y_q;

    if (frame && (cooldown_q != '0)) begin
      cooldown_d = cooldown_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable && (cooldown_q == '0) && any_free) begin
          state_d    = StScan;
          slot_d     = free_slot;
          col_d      = start_col;
          scan_cnt_d = '0;
        end
      end
      StScan: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (col_alive[col_q]) begin
          x_d     = invaders_x + 10'(HALF_SPRITE) + 10'(COL_PITCH * 32'(col_q));
          y_d     = invaders_y + 10'(ROW_PITCH * (32'(bottom) + 1));
          state_d = StLaunch;
        end else if (scan_cnt_q == ColW'(NUM_COLS - 1)) begin
          // Whole formation dead: retry on the next frame.
          state_d    = StIdle;
          cooldown_d = CdW'(1);
        end else begin
          col_d      = (col_q == ColW'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      StLaunch: begin
        // A completing handshake takes priority over an abort in the same cycle.
        if (launch_ready) begin
          state_d    = StIdle;
          cooldown_d = reload_val;
        end else if (!enable) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cooldown_q <= CdW'(COOLDOWN_FRAMES);
      slot_q     <= '0;
      col_q      <= '0;
      scan_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      slot_q     <= slot_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign launch_valid = (state_q == StLaunch);
  assign launch_slot  = slot_q;
  assign launch_x     = x_q;
  assign launch_y     = y_q;

endmodule

// File: doc/missile_scheduler.md
Name: missile_scheduler

Overview:
- Decides when the invaders fire, from which formation column, and into which of the missile slots.
- Runs a per-frame cooldown, picks a pseudo-random live column with an LFSR, and computes the launch coordinates.
- Hands each launch to the invader-missile datapath through a valid/ready handshake.
- Sits between the formation tracker (alive mask, origin, per-column bottom row) and the missile position logic.

Parameters:
- NUM_SLOTS, 3, number of missile slots (max 4).
- NUM_COLS, 11, formation columns.
- NUM_ROWS, 5, formation rows (max 8).
- COL_PITCH, 24, horizontal pixel pitch between columns.
- ROW_PITCH, 24, vertical pixel pitch between rows.
- HALF_SPRITE, 12, x offset from column origin to sprite centre.
- COOLDOWN_FRAMES, 32, base frames between launches.
- MIN_COOLDOWN, 8, floor on reload value.
- LFSR_SEED, 16'hACE1, nonzero reset value of the LFSR.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  game running; low aborts and idles the scheduler.
- frame  in  1  one-cycle pulse per video frame.
- speed  in  2  difficulty level.
- invaders_x  in  10  formation origin x.
- invaders_y  in  10  formation origin y.
- col_alive  in  NUM_COLS  bit c = column c has at least one live invader.
- col_bottom  in  NUM_COLS*3  3-bit row index of the lowest live invader per column; 0 = top row.
- slot_busy  in  NUM_SLOTS  bit s = slot s is in flight (driven by the missile datapath).
- launch_ready  in  1  datapath accepts the launch.
- launch_valid  out  1  launch request.
- launch_slot  out  2  target slot index.
- launch_x  out  10  missile start x.
- launch_y  out  10  missile start y.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; LFSR = LFSR_SEED; cooldown = COOLDOWN_FRAMES.
  - launch_valid = 0; launch_slot = 0; launch_x = 0; launch_y = 0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every clock regardless of state.
  - start_col = lfsr mod NUM_COLS.
- Cooldown counter:
  - Decrements by 1 on frame when nonzero, in all states.
  - A reload in the same cycle wins over the decrement.
  - Reload value = max(COOLDOWN_FRAMES >> speed, MIN_COOLDOWN).
- IDLE:
  - Moves to SCAN when enable && cooldown == 0 && any slot_busy bit is 0.
  - On that transition it latches:
    - slot = lowest-index free slot;
    - col = start_col;
    - scan_cnt = 0.
- SCAN, one column per cycle:
  - If col_alive[col]:
    - register launch_x = invaders_x + HALF_SPRITE + COL_PITCH*col;
    - register launch_y = invaders_y + ROW_PITCH*(col_bottom[col]+1);
    - go to LAUNCH.
  - Else if scan_cnt == NUM_COLS-1: return to IDLE with cooldown = 1 (retry next frame); no launch.
  - Else: col = (col == NUM_COLS-1) ? 0 : col+1; scan_cnt++.
- LAUNCH:
  - launch_valid = 1; launch_slot, launch_x and launch_y stay stable until the handshake.
  - On launch_valid && launch_ready: go to IDLE, launch_valid = 0 the next cycle, cooldown reloaded.
  - At most one launch per handshake.
- Latency: launch_valid rises 2+k cycles after the IDLE eligibility cycle, where k = dead columns skipped.
- Arithmetic: all coordinate arithmetic is unsigned and truncated to 10 bits (wraps mod 1024); no saturation.
- Inputs sampled while in flight:
  - Coordinates use invaders_x/y and col_bottom sampled in the SCAN hit cycle; later formation motion does not update a pending launch.
  - slot_busy changes after slot selection are ignored until return to IDLE.
- enable low in SCAN or LAUNCH: next cycle state = IDLE, launch_valid = 0, cooldown unchanged. This is the only case where valid drops without ready.
- enable low in IDLE: no transition; cooldown still counts down.
- Simultaneous launch_ready and enable low: the handshake completes (reload applies).

Decomposition:
- Shared constants package: pitch/offset values, LFSR_SEED/taps, state encoding (IDLE=0, SCAN=1, LAUNCH=2).
- One sub-module, missile_lfsr (16-bit free-running LFSR with seed parameter), reusable for other random effects.
- Priority encoder and column scan stay inline.

Test Plan:
1. Reset, enable=1, speed=0, col_alive=11'b00000100000, invaders_x=40, invaders_y=50, col5 bottom=4, no slots busy, frame every 20 cycles -> no launch before frame 32; then launch_valid with slot 0, x=172, y=170; ready -> cooldown=32.
2. slot_busy=3'b111 with cooldown 0 -> no launch for 100 cycles; slot_busy=3'b011 -> launch_slot=2.
3. col_alive=0 -> SCAN for 11 cycles, return to IDLE with cooldown=1, launch_valid never asserted; one frame later scan repeats.
4. Hold launch_ready=0 for 10 cycles with frames and formation motion -> valid, slot, x and y stable. Release with speed=2 -> cooldown=8; repeat with speed=3 -> cooldown=8 (floor).
5. Assert rst_n low mid-LAUNCH (not clock-aligned) -> launch_valid=0 immediately; cooldown=32 and LFSR=16'hACE1 after release.
6. Drop enable during SCAN -> IDLE next cycle, no launch_valid; re-enable with cooldown 0 -> launch proceeds.
